msrv32_wb_load_unit: RTL and testbench
======================================

// Module: msrv32_wb_load_unit
// PURPOSE
// - Writeback stage directly upstream of the integer register file; sole driver of its write port (wr_en/rd_addr/rd).
// - Non-load results: one-cycle writeback. Loads: wait for data-memory response, then extract, extend and write.
// - Flags read-after-load hazards against the register file read addresses while a load is outstanding.
// PARAMETERS
// - LOAD_TIMEOUT  16  cycles to wait for dmdata_valid_in before aborting the load; 0 = never time out
// - CNT_W         5   timeout counter width; LOAD_TIMEOUT < 2**CNT_W
// PORTS
// - ms_riscv32_mp_clk_in    in   1   clock, rising edge
// - ms_riscv32_mp_rst_n_in  in   1   reset, asynchronous, active-low
// - wb_valid_in         in   1   writeback request valid
// - wb_ready_out        out  1   request accepted when valid&&ready
// - wb_wr_en_in         in   1   instruction writes rd
// - wb_rd_addr_in       in   5   destination register
// - wb_result_in        in   32  ALU/CSR result (non-load)
// - wb_is_load_in       in   1   request is a load
// - wb_load_size_in     in   2   00 byte, 01 half, 10 word
// - wb_load_unsigned_in in   1   1 = zero-extend, 0 = sign-extend
// - wb_addr_lsb_in      in   2   load address bits [1:0]
// - dmdata_valid_in     in   1   memory read data valid, single-cycle pulse
// - dmdata_in           in   32  memory read word
// - rs_1_addr_in        in   5   register file read address 1
// - rs_2_addr_in        in   5   register file read address 2
// - hazard_stall_out    out  1   upstream must hold; read hits pending load rd
// - rf_wr_en_out        out  1   register file write enable
// - rf_rd_addr_out      out  5   register file write address
// - rf_rd_out           out  32  register file write data
// - load_fault_out      out  1   one-cycle pulse: load timed out, write dropped
// BEHAVIOUR
// - Reset: state IDLE, counter 0, rf_wr_en_out=0, rf_rd_addr_out=0, rf_rd_out=0, load_fault_out=0; wb_ready_out=1, hazard_stall_out=0.
// - Reset mid-load: load discarded, no write, no fault pulse.
// - States: IDLE, WAIT_LOAD. wb_ready_out = (state==IDLE), combinational.
// - IDLE, accept non-load: next edge rf_wr_en_out <= wb_wr_en_in && rd!=0; rf_rd_addr_out <= rd; rf_rd_out <= wb_result_in. Latency 1.
// - IDLE, accept load: latch rd, wr_en, size, unsigned, lsb; counter<=0; -> WAIT_LOAD. rf_wr_en_out <= 0.
// - WAIT_LOAD, dmdata_valid_in: extract per lsb (byte: dmdata_in[8*lsb+7 -: 8]; half: lsb[1] picks upper/lower 16, lsb[0] ignored; word: lsb ignored), extend to 32; next edge write as above; -> IDLE.
// - WAIT_LOAD, no valid: counter++. When counter==LOAD_TIMEOUT-1 (LOAD_TIMEOUT!=0) and no valid: load_fault_out pulses 1 cycle, no write, -> IDLE.
// - Data valid and timeout in same cycle: data wins, no fault.
// - dmdata_valid_in while IDLE: ignored.
// - Load with rd==0 or wr_en=0: still waits for response/timeout; no write, no stall.
// - rf_wr_en_out is a one-cycle pulse per write; deasserted otherwise. rf_rd_addr_out/rf_rd_out hold last value.
// - Back-to-back: on the edge leaving WAIT_LOAD, ready returns next cycle; a request accepted in the cycle rf_wr_en_out is high writes one cycle later (no overlap).
// - hazard_stall_out = (state==WAIT_LOAD) && pend_wr_en && pend_rd!=0 && (rs_1_addr_in==pend_rd || rs_2_addr_in==pend_rd); combinational.
// - Register file write-through covers the cycle rf_wr_en_out is high; no stall required then.
// CONFIGURATION
// - MSRV32_WB_LOAD_FWD_EN defined: adds outputs ld_fwd_valid_out (1) and ld_fwd_data_out (32).
// - In WAIT_LOAD cycle with dmdata_valid_in: ld_fwd_valid_out=1, ld_fwd_data_out=extended data (combinational), hazard_stall_out=0.
// - Otherwise ld_fwd_valid_out=0, ld_fwd_data_out=0.
// - Not defined: ports absent; hazard_stall_out stays high through the dmdata_valid_in cycle.
// TESTING
// - Non-load: rd=5, result=0xDEADBEEF, wr_en=1 -> next cycle rf_wr_en_out=1, addr=5, data=0xDEADBEEF; rd=0 -> rf_wr_en_out=0.
// - Load byte signed lsb=2, rd=7, dmdata=0x0080_0000 after 3 cycles -> write 0xFFFFFF80 to x7; unsigned -> 0x00000080.
// - Load half lsb=2, unsigned, dmdata=0xBEEF1234 -> 0x0000BEEF; word -> 0xBEEF1234.
// - Pending load rd=9, rs_1_addr_in=9 -> hazard_stall_out=1 until response; rs=0 or rd=0 -> 0.
// - No response, LOAD_TIMEOUT=16 -> load_fault_out pulse on 16th wait cycle, no write, wb_ready_out=1 next cycle.
// - Assert rst_n low during WAIT_LOAD -> all outputs 0, wb_ready_out=1, no write after later dmdata_valid_in.

Source files
------------

// File: rtl/msrv32_wb_load_unit.sv
// Writeback stage feeding the integer register file: one-cycle writeback for ALU/CSR results,
// load extraction/extension after the data-memory response, load timeout and read-after-load hazard flag.
// Optional feature macro: MSRV32_WB_LOAD_FWD_EN (adds load-data forwarding outputs).
module msrv32_wb_load_unit #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        wb_valid_in,
    output logic        wb_ready_out,
    input  logic        wb_wr_en_in,
    input  logic [4:0]  wb_rd_addr_in,
    input  logic [31:0] wb_result_in,
    input  logic        wb_is_load_in,
    input  logic [1:0]  wb_load_size_in,
    input  logic        wb_load_unsigned_in,
    input  logic [1:0]  wb_addr_lsb_in,
    input  logic        dmdata_valid_in,
    input  logic [31:0] dmdata_in,
    input  logic [4:0]  rs_1_addr_in,
    input  logic [4:0]  rs_2_addr_in,
    output logic        hazard_stall_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rf_rd_addr_out,
    output logic [31:0] rf_rd_out,
    output logic        load_fault_out
`ifdef MSRV32_WB_LOAD_FWD_EN
    ,
    output logic        ld_fwd_valid_out,
    output logic [31:0] ld_fwd_data_out
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    localparam logic             TMO_EN   = (LOAD_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [4:0]        pend_rd_r;
    logic              pend_wr_en_r;
    logic [1:0]        pend_size_r;
    logic              pend_uns_r;
    logic [1:0]        pend_lsb_r;
    logic              wr_en_s;
    logic [4:0]        wr_addr_s;
    logic [31:0]       wr_data_s;
    logic              fault_s;
    logic              load_accept_s;
    logic              rd_hit_s;
    logic              data_here_s;
    logic [31:0]       ext_data_s;

    // Byte/half/word extraction from the aligned memory word, then sign/zero extension
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                                input logic [1:0] lsb, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lsb)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lsb[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign wb_ready_out  = (state_r == IDLE);
    assign load_accept_s = (state_r == IDLE) && wb_valid_in && wb_is_load_in;
    assign data_here_s   = (state_r == WAIT_LOAD) && dmdata_valid_in;
    assign ext_data_s    = extend_load(pend_size_r, pend_uns_r, pend_lsb_r, dmdata_in);
    assign rd_hit_s      = (state_r == WAIT_LOAD) && pend_wr_en_r && (pend_rd_r != 5'd0) &&
                           ((rs_1_addr_in == pend_rd_r) || (rs_2_addr_in == pend_rd_r));

`ifdef MSRV32_WB_LOAD_FWD_EN
    // Response data bypasses the register file in its arrival cycle, so no stall is needed then
    assign hazard_stall_out = rd_hit_s && !dmdata_valid_in;
    assign ld_fwd_valid_out = data_here_s;
    assign ld_fwd_data_out  = data_here_s ? ext_data_s : 32'd0;
`else
    assign hazard_stall_out = rd_hit_s;
`endif

    // Next-state, timeout counting and register-file write selection
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        wr_en_s   = 1'b0;
        wr_addr_s = rf_rd_addr_out;
        wr_data_s = rf_rd_out;
        fault_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (wb_valid_in && wb_is_load_in) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = WAIT_LOAD;
                end else if (wb_valid_in) begin
                    wr_en_s   = wb_wr_en_in && (wb_rd_addr_in != 5'd0);
                    wr_addr_s = wb_rd_addr_in;
                    wr_data_s = wb_result_in;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (dmdata_valid_in) begin
                    wr_en_s   = pend_wr_en_r && (pend_rd_r != 5'd0);
                    wr_addr_s = pend_rd_r;
                    wr_data_s = ext_data_s;
                    state_s   = IDLE;
                end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
                    fault_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and registered register-file/fault outputs
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            rf_wr_en_out   <= 1'b0;
            rf_rd_addr_out <= 5'd0;
            rf_rd_out      <= 32'd0;
            load_fault_out <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            rf_wr_en_out   <= wr_en_s;
            rf_rd_addr_out <= wr_addr_s;
            rf_rd_out      <= wr_data_s;
            load_fault_out <= fault_s;
        end
    end

    // Attributes of the outstanding load, captured when it is accepted
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            pend_rd_r    <= 5'd0;
            pend_wr_en_r <= 1'b0;
            pend_size_r  <= 2'b00;
            pend_uns_r   <= 1'b0;
            pend_lsb_r   <= 2'b00;
        end else if (load_accept_s) begin
            pend_rd_r    <= wb_rd_addr_in;
            pend_wr_en_r <= wb_wr_en_in;
            pend_size_r  <= wb_load_size_in;
            pend_uns_r   <= wb_load_unsigned_in;
            pend_lsb_r   <= wb_addr_lsb_in;
        end else begin
            pend_rd_r    <= pend_rd_r;
            pend_wr_en_r <= pend_wr_en_r;
            pend_size_r  <= pend_size_r;
            pend_uns_r   <= pend_uns_r;
            pend_lsb_r   <= pend_lsb_r;
        end
    end

endmodule

// File: tb/tb_msrv32_wb_load_unit.sv
// Scoreboard bench for msrv32_wb_load_unit: directed requests push expected writes/faults,
// a negedge monitor pops and compares whenever the register-file port or fault pulse fires.
module tb_msrv32_wb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_result = 32'd0;
    logic        wb_is_load = 1'b0;
    logic [1:0]  wb_size = 2'b00;
    logic        wb_uns = 1'b0;
    logic [1:0]  wb_lsb = 2'b00;
    logic        dm_valid = 1'b0;
    logic [31:0] dm_data = 32'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        hazard;
    logic        rf_wr_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        fault;
`ifdef MSRV32_WB_LOAD_FWD_EN
    logic        fwd_valid;
    logic [31:0] fwd_data;
`endif

    msrv32_wb_load_unit #(.LOAD_TIMEOUT(16), .CNT_W(5)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .wb_valid_in            (wb_valid),
        .wb_ready_out           (wb_ready),
        .wb_wr_en_in            (wb_wr_en),
        .wb_rd_addr_in          (wb_rd),
        .wb_result_in           (wb_result),
        .wb_is_load_in          (wb_is_load),
        .wb_load_size_in        (wb_size),
        .wb_load_unsigned_in    (wb_uns),
        .wb_addr_lsb_in         (wb_lsb),
        .dmdata_valid_in        (dm_valid),
        .dmdata_in              (dm_data),
        .rs_1_addr_in           (rs1),
        .rs_2_addr_in           (rs2),
        .hazard_stall_out       (hazard),
        .rf_wr_en_out           (rf_wr_en),
        .rf_rd_addr_out         (rf_addr),
        .rf_rd_out              (rf_data),
        .load_fault_out         (fault)
`ifdef MSRV32_WB_LOAD_FWD_EN
        ,
        .ld_fwd_valid_out       (fwd_valid),
        .ld_fwd_data_out        (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // 2'b10 write, 2'b01 fault
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every write pulse or fault pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (rf_wr_en === 1'b1 || fault === 1'b1)) begin
            if (q.size() == 0) begin
                check("unexpected_event", {30'd0, rf_wr_en, fault}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind", {30'd0, rf_wr_en, fault}, {30'd0, e.kind});
                check("event_cycle", cyc, e.cyc);
                if (e.kind == 2'b10) begin
                    check("wr_addr", {27'd0, rf_addr}, {27'd0, e.addr});
                    check("wr_data", rf_data, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = 2'b10; e.addr = a; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic non_load(input logic [4:0] rd, input logic [31:0] res, input logic we);
        check("ready_before_req", {31'd0, wb_ready}, 32'd1);
        wb_valid = 1'b1; wb_is_load = 1'b0; wb_wr_en = we; wb_rd = rd; wb_result = res;
        if (we && rd != 5'd0) expect_write(rd, res, cyc + 1);
        step();
        wb_valid = 1'b0;
    endtask

    task automatic load_req(input logic [4:0] rd, input logic we, input logic [1:0] size,
                            input logic uns, input logic [1:0] lsb);
        check("ready_before_load", {31'd0, wb_ready}, 32'd1);
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_wr_en = we; wb_rd = rd;
        wb_size = size; wb_uns = uns; wb_lsb = lsb;
        step();
        wb_valid = 1'b0; wb_is_load = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] word, input logic we_exp,
                           input logic [4:0] rd, input logic [31:0] val);
        for (int i = 0; i < delay; i++) begin
            check("ready_low_waiting", {31'd0, wb_ready}, 32'd0);
            step();
        end
        dm_valid = 1'b1; dm_data = word;
        #1;
`ifdef MSRV32_WB_LOAD_FWD_EN
        check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("fwd_data", fwd_data, val);
`endif
        if (we_exp) expect_write(rd, val, cyc + 1);
        step();
        dm_valid = 1'b0;
        check("ready_after_resp", {31'd0, wb_ready}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("rst_addr", {27'd0, rf_addr}, 32'd0);
        check("rst_data", rf_data, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_ready", {31'd0, wb_ready}, 32'd1);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Non-load writebacks, including back-to-back and rd=0
        non_load(5'd5, 32'hDEADBEEF, 1'b1);
        non_load(5'd0, 32'h11111111, 1'b1);
        non_load(5'd6, 32'h22222222, 1'b1);
        non_load(5'd8, 32'h33333333, 1'b1);
        non_load(5'd9, 32'h44444444, 1'b0);
        step();

        // Loads: byte, half, word with various lanes and extensions
        load_req(5'd7, 1'b1, 2'b00, 1'b0, 2'd2);  respond(3, 32'h0080_0000, 1'b1, 5'd7, 32'hFFFFFF80);
        load_req(5'd7, 1'b1, 2'b00, 1'b1, 2'd2);  respond(3, 32'h0080_0000, 1'b1, 5'd7, 32'h00000080);
        load_req(5'd10, 1'b1, 2'b01, 1'b1, 2'd2); respond(1, 32'hBEEF1234, 1'b1, 5'd10, 32'h0000BEEF);
        load_req(5'd11, 1'b1, 2'b01, 1'b0, 2'd0); respond(0, 32'hBEEF8234, 1'b1, 5'd11, 32'hFFFF8234);
        load_req(5'd12, 1'b1, 2'b01, 1'b0, 2'd3); respond(2, 32'hBEEF1234, 1'b1, 5'd12, 32'hFFFFBEEF);
        load_req(5'd13, 1'b1, 2'b10, 1'b0, 2'd3); respond(2, 32'hBEEF1234, 1'b1, 5'd13, 32'hBEEF1234);
        load_req(5'd14, 1'b1, 2'b00, 1'b0, 2'd0); respond(1, 32'h1234567F, 1'b1, 5'd14, 32'h0000007F);
        load_req(5'd15, 1'b1, 2'b00, 1'b0, 2'd3); respond(1, 32'h80000000, 1'b1, 5'd15, 32'hFFFFFF80);
        load_req(5'd16, 1'b1, 2'b00, 1'b1, 2'd1); respond(1, 32'h0000AB00, 1'b1, 5'd16, 32'h000000AB);
        non_load(5'd17, 32'h55555555, 1'b1);

        // Hazard against a pending load of x9
        load_req(5'd9, 1'b1, 2'b10, 1'b0, 2'd0);
        rs1 = 5'd9; rs2 = 5'd3; #1;
        check("hazard_rs1", {31'd0, hazard}, 32'd1);
        rs1 = 5'd0; rs2 = 5'd9; #1;
        check("hazard_rs2", {31'd0, hazard}, 32'd1);
        rs1 = 5'd3; rs2 = 5'd4; #1;
        check("hazard_nohit", {31'd0, hazard}, 32'd0);
        step();
        rs1 = 5'd9;
        dm_valid = 1'b1; dm_data = 32'hCAFEF00D; #1;
`ifdef MSRV32_WB_LOAD_FWD_EN
        check("hazard_resp_cycle", {31'd0, hazard}, 32'd0);
`else
        check("hazard_resp_cycle", {31'd0, hazard}, 32'd1);
`endif
        expect_write(5'd9, 32'hCAFEF00D, cyc + 1);
        step();
        dm_valid = 1'b0;
        check("hazard_after_resp", {31'd0, hazard}, 32'd0);

        // Load to x0 and load without wr_en: wait for response, no write, no stall
        load_req(5'd0, 1'b1, 2'b10, 1'b0, 2'd0);
        rs1 = 5'd0; #1;
        check("hazard_rd0", {31'd0, hazard}, 32'd0);
        respond(2, 32'h12345678, 1'b0, 5'd0, 32'h12345678);
        load_req(5'd9, 1'b0, 2'b10, 1'b0, 2'd0);
        rs1 = 5'd9; #1;
        check("hazard_no_wr_en", {31'd0, hazard}, 32'd0);
        respond(1, 32'h87654321, 1'b0, 5'd9, 32'h87654321);
        rs1 = 5'd0;

        // Data arriving on the last wait cycle beats the timeout
        load_req(5'd18, 1'b1, 2'b10, 1'b0, 2'd0);
        respond(15, 32'h0BADC0DE, 1'b1, 5'd18, 32'h0BADC0DE);

        // Timeout: fault pulse after the 16th wait cycle, no write
        load_req(5'd19, 1'b1, 2'b10, 1'b0, 2'd0);
        begin
            exp_t e;
            e.kind = 2'b01; e.addr = 5'd0; e.data = 32'd0; e.cyc = cyc + 16;
            q.push_back(e);
        end
        for (int i = 0; i < 15; i++) step();
        check("ready_last_wait", {31'd0, wb_ready}, 32'd0);
        step();
        check("ready_after_fault", {31'd0, wb_ready}, 32'd1);
        check("fault_pulse", {31'd0, fault}, 32'd1);
        step();
        check("fault_one_cycle", {31'd0, fault}, 32'd0);

        // Memory data while idle is ignored
        dm_valid = 1'b1; dm_data = 32'hFFFFFFFF;
        step();
        dm_valid = 1'b0;

        // Reset in the middle of a load
        non_load(5'd20, 32'h66666666, 1'b1);
        load_req(5'd21, 1'b1, 2'b10, 1'b0, 2'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("midrst_addr", {27'd0, rf_addr}, 32'd0);
        check("midrst_data", rf_data, 32'd0);
        check("midrst_fault", {31'd0, fault}, 32'd0);
        check("midrst_ready", {31'd0, wb_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        dm_valid = 1'b1; dm_data = 32'hA5A5A5A5;
        step();
        dm_valid = 1'b0;
        step();
        check("post_rst_ready", {31'd0, wb_ready}, 32'd1);
        non_load(5'd22, 32'h77777777, 1'b1);
        step();
        step();

        check("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
